// File: rtl/inst_fetch_axi_pkg.sv
// Shared definitions for the MIPS32 instruction-fetch stage: FSM encoding,
// reset PC, fetch exception bit positions and the AXI OKAY response code.
package inst_fetch_axi_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_DROP_ADDR,
        S_DROP_DATA
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

    localparam int EXC_IF_ADEL   = 13;
    localparam int EXC_IF_BUSERR = 14;

    localparam logic [31:0] EXC_ADEL_MASK   = 32'h1 << EXC_IF_ADEL;
    localparam logic [31:0] EXC_BUSERR_MASK = 32'h1 << EXC_IF_BUSERR;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

endpackage

// File: rtl/inst_fetch_axi.sv
// Instruction fetch over AXI4 (single beat, one outstanding read) feeding IF/ID.
// Optional FETCH_BUSERR_EN: a non-OKAY rresp flags an instruction bus error.
module inst_fetch_axi
    import inst_fetch_axi_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic [31:0] new_pc,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_address_i,
    input  logic        next_pc_valid,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    output logic        valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic [31:0] pc_excepttype_o
);

    fetch_state_t state, state_next;

    logic [31:0] pc;
    logic [31:0] pend_tgt;
    logic        pend_v;
    logic        adel_hold;
    logic        issue;
    logic        misaligned;
    logic        deliver;
    logic        bus_err;
    logic [31:0] next_seq_pc;

`ifdef FETCH_BUSERR_EN
    assign bus_err = (rresp != AXI_RESP_OKAY);
    logic unused_inputs;
    assign unused_inputs = ^stall[5:1];
`else
    assign bus_err = 1'b0;
    logic unused_inputs;
    assign unused_inputs = ^{stall[5:1], rresp};
`endif

    // A misaligned PC reports AdEL once, then holds until a flush redirects it.
    assign issue      = (state == S_IDLE) && next_pc_valid && !stall[0] && !flush && !adel_hold;
    assign misaligned = (pc[1:0] != 2'b00);
    assign deliver    = (state == S_DATA) && rvalid && !flush;

    assign arvalid = (state == S_ADDR) || (state == S_DROP_ADDR);
    assign rready  = (state == S_DATA) || (state == S_DROP_DATA);

    // A branch seen in the same cycle as the delay-slot beat applies immediately.
    assign next_seq_pc = branch_flag_i ? branch_target_address_i :
                         pend_v        ? pend_tgt                :
                                         araddr + 32'd4;

    // NOTE: state_next gets its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:      if (issue && !misaligned) state_next = S_ADDR;
            S_ADDR: begin
                if (flush)        state_next = arready ? S_DROP_DATA : S_DROP_ADDR;
                else if (arready) state_next = S_DATA;
            end
            S_DATA: begin
                if (rvalid)     state_next = S_IDLE;
                else if (flush) state_next = S_DROP_DATA;
            end
            S_DROP_ADDR: if (arready) state_next = S_DROP_DATA;
            S_DROP_DATA: if (rvalid)  state_next = S_IDLE;
            default:     state_next = S_IDLE;
        endcase
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            pc              <= RESET_PC;
            pend_tgt        <= '0;
            pend_v          <= 1'b0;
            adel_hold       <= 1'b0;
            araddr          <= '0;
            valid           <= 1'b0;
            if_pc           <= '0;
            if_inst         <= '0;
            pc_excepttype_o <= '0;
        end else begin
            state <= state_next;
            valid <= 1'b0;
            if (flush) begin
                pc        <= new_pc;
                pend_v    <= 1'b0;
                adel_hold <= 1'b0;
            end else begin
                if (deliver) begin
                    pc              <= next_seq_pc;
                    pend_v          <= 1'b0;
                    valid           <= 1'b1;
                    if_pc           <= araddr;
                    if_inst         <= bus_err ? 32'h0 : rdata;
                    pc_excepttype_o <= bus_err ? EXC_BUSERR_MASK : 32'h0;
                end else if (branch_flag_i) begin
                    pend_v   <= 1'b1;
                    pend_tgt <= branch_target_address_i;
                end

                if (issue && !misaligned) begin
                    araddr <= pc;
                end

                if (issue && misaligned) begin
                    valid           <= 1'b1;
                    if_pc           <= pc;
                    if_inst         <= 32'h0;
                    pc_excepttype_o <= EXC_ADEL_MASK;
                    adel_hold       <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_axi.sv
// Self-checking bench for inst_fetch_axi: directed scenarios then random traffic,
// with a transaction-level PC/redirect model acting alongside the AXI slave.
module tb_inst_fetch_axi;

    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        branch_flag_i;
    logic [31:0] branch_target_address_i;
    logic        next_pc_valid;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic        valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic [31:0] pc_excepttype_o;

    always #5 clk = ~clk;

    inst_fetch_axi #(.RESET_PC(RESET_PC)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .stall                   (stall),
        .flush                   (flush),
        .new_pc                  (new_pc),
        .branch_flag_i           (branch_flag_i),
        .branch_target_address_i (branch_target_address_i),
        .next_pc_valid           (next_pc_valid),
        .araddr                  (araddr),
        .arvalid                 (arvalid),
        .arready                 (arready),
        .rdata                   (rdata),
        .rresp                   (rresp),
        .rvalid                  (rvalid),
        .rready                  (rready),
        .valid                   (valid),
        .if_pc                   (if_pc),
        .if_inst                 (if_inst),
        .pc_excepttype_o         (pc_excepttype_o)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: architectural fetch PC, pending branch, slave-side read tracking.
    logic [31:0] m_pc, m_tgt, m_rd_addr;
    logic        m_pend, m_out, m_drop, m_adel_done;
    logic        e_valid;
    logic [31:0] e_pc, e_inst, e_exc;
    int          deliv_cnt;

    logic [31:0] seen_ar[$];
    logic [31:0] seen_pc[$];
    logic [31:0] last_exc, last_inst;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == RESET_PC) return 32'h2408_0001;
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs of the last edge, drive inputs, advance the model, wait.
    task automatic step(input logic ar, input logic rv, input logic fl, input logic [31:0] npc,
                        input logic br, input logic [31:0] btgt, input logic nv, input logic st0,
                        input logic [1:0] resp);
        logic ar_hs, r_hs, deliver, adel_fire;
        check("valid", 32'(valid), 32'(e_valid));
        if (e_valid) begin
            check("if_pc", if_pc, e_pc);
            check("if_inst", if_inst, e_inst);
            check("excepttype", pc_excepttype_o, e_exc);
            seen_pc.push_back(if_pc);
            last_exc  = pc_excepttype_o;
            last_inst = if_inst;
        end
        check("rready", 32'(rready), 32'(m_out));

        arready                 = ar;
        rvalid                  = rv && m_out;
        rdata                   = (rv && m_out) ? mem_word(m_rd_addr) : 32'hDEAD_BEEF;
        rresp                   = resp;
        flush                   = fl;
        new_pc                  = npc;
        branch_flag_i           = br;
        branch_target_address_i = btgt;
        next_pc_valid           = nv;
        stall                   = {5'($urandom), st0};

        ar_hs     = arvalid && ar;
        r_hs      = rv && m_out;
        deliver   = r_hs && !m_drop && !fl;
        adel_fire = !arvalid && !m_out && nv && !st0 && !fl && (m_pc[1:0] != 2'b00) && !m_adel_done;
        e_valid   = 1'b0;

        if (ar_hs && !m_drop) begin
            check("araddr", araddr, m_pc);
            seen_ar.push_back(araddr);
            m_rd_addr = m_pc;
        end
        if (deliver) begin
            e_valid = 1'b1;
            e_pc    = m_rd_addr;
            e_inst  = mem_word(m_rd_addr);
            e_exc   = 32'h0;
`ifdef FETCH_BUSERR_EN
            if (resp != 2'b00) begin
                e_inst = 32'h0;
                e_exc  = 32'h0000_4000;
            end
`endif
            m_pc   = br ? btgt : (m_pend ? m_tgt : m_rd_addr + 32'd4);
            m_pend = 1'b0;
            deliv_cnt++;
        end
        if (adel_fire) begin
            e_valid     = 1'b1;
            e_pc        = m_pc;
            e_inst      = 32'h0;
            e_exc       = 32'h0000_2000;
            m_adel_done = 1'b1;
            deliv_cnt++;
        end
        if (fl) begin
            if (arvalid || m_out) m_drop = 1'b1;
            m_pc        = npc;
            m_pend      = 1'b0;
            m_adel_done = 1'b0;
        end else if (br && !deliver) begin
            m_pend = 1'b1;
            m_tgt  = btgt;
        end
        if (ar_hs) m_out = 1'b1;
        if (r_hs) begin
            m_out  = 1'b0;
            m_drop = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic step_s(input logic ar, input logic rv, input logic nv);
        step(ar, rv, 1'b0, 32'h0, 1'b0, 32'h0, nv, 1'b0, 2'b00);
    endtask

    task automatic run_until_deliv(input int target);
        int budget = 200;
        while (deliv_cnt < target && budget > 0) begin
            step_s(1'b1, 1'b1, 1'b1);
            budget--;
        end
        check("deliv_timeout", 32'(deliv_cnt >= target), 32'd1);
    endtask

    task automatic reach_data();
        int budget = 50;
        while (!m_out && budget > 0) begin
            step_s(1'b1, 1'b0, 1'b1);
            budget--;
        end
        check("reach_data", 32'(m_out), 32'd1);
    endtask

    initial begin
        int budget;
        int base;
        logic [31:0] r;

        rst = 1'b1; stall = '0; flush = 1'b0; new_pc = '0; branch_flag_i = 1'b0;
        branch_target_address_i = '0; next_pc_valid = 1'b1; arready = 1'b0;
        rdata = '0; rresp = 2'b00; rvalid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_arvalid", 32'(arvalid), 32'd0);
        check("rst_araddr", araddr, 32'h0);
        check("rst_rready", 32'(rready), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_if_pc", if_pc, 32'h0);
        check("rst_if_inst", if_inst, 32'h0);
        check("rst_exc", pc_excepttype_o, 32'h0);

        m_pc = RESET_PC; m_tgt = '0; m_rd_addr = '0; m_pend = 1'b0; m_out = 1'b0;
        m_drop = 1'b0; m_adel_done = 1'b0; e_valid = 1'b0; e_pc = '0; e_inst = '0;
        e_exc = '0; deliv_cnt = 0; last_exc = '0; last_inst = '0;
        rst = 1'b0;

        // Boot fetches, then a branch whose delay slot is 0xBFC00008.
        run_until_deliv(2);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hBFC0_0100, 1'b1, 1'b0, 2'b00);
        run_until_deliv(4);
        step_s(1'b0, 1'b0, 1'b0);
        check("boot_ar0", seen_ar[0], 32'hBFC0_0000);
        check("boot_ar1", seen_ar[1], 32'hBFC0_0004);
        check("delay_ar", seen_ar[2], 32'hBFC0_0008);
        check("branch_ar", seen_ar[3], 32'hBFC0_0100);
        check("boot_inst", 32'(seen_pc.size()), 32'd4);
        check("delay_pc", seen_pc[2], 32'hBFC0_0008);

        // Flush while the read data is outstanding.
        reach_data();
        step(1'b0, 1'b0, 1'b1, 32'hBFC0_0380, 1'b0, 32'h0, 1'b1, 1'b0, 2'b00);
        step_s(1'b0, 1'b1, 1'b1);
        base = deliv_cnt;
        run_until_deliv(base + 1);
        step_s(1'b0, 1'b0, 1'b0);
        check("flush_data_ar", seen_ar[$], 32'hBFC0_0380);
        check("flush_data_pc", seen_pc[$], 32'hBFC0_0380);

        // Flush in ADDR with arready held low for three cycles.
        budget = 20;
        while (!arvalid && budget > 0) begin
            step_s(1'b0, 1'b0, 1'b1);
            budget--;
        end
        check("reach_addr", 32'(arvalid), 32'd1);
        step(1'b0, 1'b0, 1'b1, 32'hBFC0_0380, 1'b0, 32'h0, 1'b1, 1'b0, 2'b00);
        repeat (2) begin
            check("arvalid_hold", 32'(arvalid), 32'd1);
            step_s(1'b0, 1'b0, 1'b1);
        end
        check("arvalid_hold", 32'(arvalid), 32'd1);
        step_s(1'b1, 1'b0, 1'b1);
        step_s(1'b0, 1'b1, 1'b1);
        base = deliv_cnt;
        run_until_deliv(base + 1);
        step_s(1'b0, 1'b0, 1'b0);
        check("flush_addr_ar", seen_ar[$], 32'hBFC0_0380);

        // Misaligned redirect: AdEL reported once, no AR issued.
        step(1'b0, 1'b0, 1'b1, 32'hBFC0_0002, 1'b0, 32'h0, 1'b0, 1'b0, 2'b00);
        repeat (5) begin
            step_s(1'b1, 1'b1, 1'b1);
            check("adel_no_ar", 32'(arvalid), 32'd0);
        end
        check("adel_pc", seen_pc[$], 32'hBFC0_0002);
        check("adel_exc", last_exc, 32'h0000_2000);
        check("adel_inst", last_inst, 32'h0);

        // Error response on a delivered beat.
        step(1'b0, 1'b0, 1'b1, 32'hBFC0_0010, 1'b0, 32'h0, 1'b0, 1'b0, 2'b00);
        reach_data();
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 2'b10);
        step_s(1'b0, 1'b0, 1'b0);
        check("buserr_pc", seen_pc[$], 32'hBFC0_0010);
`ifdef FETCH_BUSERR_EN
        check("buserr_exc", last_exc, 32'h0000_4000);
        check("buserr_inst", last_inst, 32'h0);
`else
        check("buserr_exc", last_exc, 32'h0);
        check("buserr_inst", last_inst, mem_word(32'hBFC0_0010));
`endif

        // Random traffic: handshake delays, stalls, credits, branches and flushes.
        for (int i = 0; i < 3000; i++) begin
            logic ar_r, rv_r, fl_r, br_r, nv_r, st_r;
            logic [31:0] npc_r, tgt_r;
            ar_r  = ($urandom_range(99) < 70);
            rv_r  = ($urandom_range(99) < 70);
            fl_r  = ($urandom_range(99) < 3);
            br_r  = ($urandom_range(99) < 5);
            nv_r  = ($urandom_range(99) < 80);
            st_r  = ($urandom_range(99) < 20);
            r     = $urandom;
            npc_r = {20'hBFC00, r[9:0], 2'b00};
            r     = $urandom;
            tgt_r = {20'hBFC01, r[9:0], 2'b00};
            step(ar_r, rv_r, fl_r, npc_r, br_r, tgt_r, nv_r, st_r, 2'b00);
        end
        repeat (3) step_s(1'b1, 1'b1, 1'b0);
        check("random_progress", 32'(deliv_cnt > 100), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
